// File: rtl/dual_comb_diff.sv
// Sliding-window differencer for dual-number samples: d = a - a[n-DEPTH], j_d = j_a - j_a[n-DEPTH].
// Optional saturation of each difference part is enabled by defining DUAL_COMB_SAT_EN.
module dual_comb_diff #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] j_a,
    output logic         out_valid,
    output logic [W-1:0] d,
    output logic [W-1:0] j_d,
    output logic         primed,
    output logic         ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [FW-1:0]  fill;
    logic           accept;
    logic [2*W-1:0] old_entry;
    logic [W-1:0]   old_a;
    logic [W-1:0]   old_j;
    logic [W-1:0]   res_a;
    logic [W-1:0]   res_j;
    logic           ovf_nxt;

    assign accept = in_valid && !clear;
    assign primed = (fill == FW'(DEPTH));

    // Until the window is full the stale RAM contents are masked, so the RAM needs no reset.
    assign old_entry = primed ? mem[wr_ptr] : '0;
    assign old_a     = old_entry[2*W-1:W];
    assign old_j     = old_entry[W-1:0];

`ifdef DUAL_COMB_SAT_EN
    logic [W:0] diff_a;
    logic [W:0] diff_j;
    logic       sat_a;
    logic       sat_j;

    always_comb begin
        diff_a = {a[W-1], a} - {old_a[W-1], old_a};
        diff_j = {j_a[W-1], j_a} - {old_j[W-1], old_j};
        sat_a  = diff_a[W] ^ diff_a[W-1];
        sat_j  = diff_j[W] ^ diff_j[W-1];
        res_a  = diff_a[W-1:0];
        res_j  = diff_j[W-1:0];
        if (sat_a) res_a = diff_a[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        if (sat_j) res_j = diff_j[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        ovf_nxt = sat_a | sat_j;
    end
`else
    always_comb begin
        res_a   = a - old_a;
        res_j   = j_a - old_j;
        ovf_nxt = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {a, j_a};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            d         <= '0;
            j_d       <= '0;
            ovf       <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
                if (!primed) fill <= fill + FW'(1);
                d   <= res_a;
                j_d <= res_j;
                ovf <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dual_comb_diff.sv
// Directed bench for dual_comb_diff: a DEPTH=4 instance for the windowing tests and a DEPTH=2
// instance for the overflow corner; both share stimulus.
module tb_dual_comb_diff;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] j_a = '0;

    logic         v4, p4, o4, v2, p2, o2;
    logic [W-1:0] d4, jd4, d2, jd2;

    int n_pass = 0;
    int n_total = 0;

    dual_comb_diff #(.W(W), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .j_a(j_a),
        .out_valid(v4), .d(d4), .j_d(jd4), .primed(p4), .ovf(o4)
    );

    dual_comb_diff #(.W(W), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .j_a(j_a),
        .out_valid(v2), .d(d2), .j_d(jd2), .primed(p2), .ovf(o2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        clr;
        logic [31:0] av;
        logic [31:0] jv;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] ejd;
        logic        ep;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic add(input logic iv, input logic clr, input int av, input int jv,
                       input logic ev, input int ed, input int ejd, input logic ep);
        vec_t v;
        v.iv = iv; v.clr = clr; v.av = av; v.jv = jv;
        v.ev = ev; v.ed = ed; v.ejd = ejd; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic clr, input logic [31:0] av, input logic [31:0] jv);
        @(negedge clk);
        in_valid = iv; clear = clr; a = av; j_a = jv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // back-to-back fill, DEPTH=4
        for (int i = 1; i <= 6; i++)
            add(1, 0, 10 * i, i, 1, (i <= 4) ? 10 * i : 40, (i <= 4) ? i : 4, i >= 4);
        add(0, 1, 0, 0, 0, 40, 4, 0);
        // gapped strobes, outputs hold through idle cycles
        for (int i = 1; i <= 6; i++) begin
            add(1, 0, 10 * i, i, 1, (i <= 4) ? 10 * i : 40, (i <= 4) ? i : 4, i >= 4);
            add(0, 0, 12345, 54321, 0, (i <= 4) ? 10 * i : 40, (i <= 4) ? i : 4, i >= 4);
            add(0, 0, 777, 888, 0, (i <= 4) ? 10 * i : 40, (i <= 4) ? i : 4, i >= 4);
        end
        // clear beats in_valid, then restart from an empty window
        add(1, 1, 99, 99, 0, 40, 4, 0);
        add(1, 0, 7, -3, 1, 7, -3, 0);

        // reset held with random traffic
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom; j_a = $urandom;
            @(posedge clk);
            #1;
            check("rst v4", {31'b0, v4}, 0);
            check("rst d4", d4, 0);
            check("rst jd4", jd4, 0);
            check("rst p4", {31'b0, p4}, 0);
            check("rst o4", {31'b0, o4}, 0);
            check("rst v2", {31'b0, v2}, 0);
            check("rst d2", d2, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].clr, vecs[i].av, vecs[i].jv);
            check($sformatf("row%0d out_valid", i), {31'b0, v4}, {31'b0, vecs[i].ev});
            check($sformatf("row%0d d", i), d4, vecs[i].ed);
            check($sformatf("row%0d j_d", i), jd4, vecs[i].ejd);
            check($sformatf("row%0d primed", i), {31'b0, p4}, {31'b0, vecs[i].ep});
            check($sformatf("row%0d ovf", i), {31'b0, o4}, 0);
        end

        // async reset mid-stream
        drive(0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) drive(1, 0, i, 10 * i);
        check("pre-rst d", d4, 4);
        check("pre-rst j_d", jd4, 40);
        check("pre-rst primed", {31'b0, p4}, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, v4}, 0);
        check("async rst d", d4, 0);
        check("async rst j_d", jd4, 0);
        check("async rst primed", {31'b0, p4}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 5, 6);
        check("post-rst out_valid", {31'b0, v4}, 1);
        check("post-rst d", d4, 5);
        check("post-rst j_d", jd4, 6);
        check("post-rst primed", {31'b0, p4}, 0);

        // overflow corner, DEPTH=2
        drive(0, 1, 0, 0);
        drive(1, 0, 32'hFFFF_FFFF, 1);
        check("ovf s1 d", d2, 32'hFFFF_FFFF);
        check("ovf s1 j_d", jd2, 1);
        check("ovf s1 ovf", {31'b0, o2}, 0);
        drive(1, 0, 0, 0);
        check("ovf s2 d", d2, 0);
        check("ovf s2 primed", {31'b0, p2}, 1);
        drive(1, 0, 32'h7FFF_FFFF, 32'h8000_0000);
        check("ovf s3 out_valid", {31'b0, v2}, 1);
`ifdef DUAL_COMB_SAT_EN
        check("ovf s3 d", d2, 32'h7FFF_FFFF);
        check("ovf s3 j_d", jd2, 32'h8000_0000);
        check("ovf s3 ovf", {31'b0, o2}, 1);
        drive(0, 0, 0, 0);
        check("ovf hold ovf", {31'b0, o2}, 1);
        check("ovf hold d", d2, 32'h7FFF_FFFF);
`else
        check("ovf s3 d", d2, 32'h8000_0000);
        check("ovf s3 j_d", jd2, 32'h7FFF_FFFF);
        check("ovf s3 ovf", {31'b0, o2}, 0);
        drive(0, 0, 0, 0);
        check("ovf hold ovf", {31'b0, o2}, 0);
        check("ovf hold d", d2, 32'h8000_0000);
`endif
        check("ovf hold out_valid", {31'b0, v2}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
